// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle for the data-memory port arbiter: PIPE and DMA requester
// channels plus the single-port memory side.
interface dmem_port_arbiter_if #(
  parameter int WORD_LEN = 32
);
  logic                pipe_req;
  logic                pipe_we;
  logic [WORD_LEN-1:0] pipe_addr;
  logic [WORD_LEN-1:0] pipe_wdata;
  logic                pipe_stall;
  logic [WORD_LEN-1:0] pipe_rdata;
  logic                pipe_done;

  logic                dma_req;
  logic                dma_we;
  logic [WORD_LEN-1:0] dma_addr;
  logic [WORD_LEN-1:0] dma_wdata;
  logic [WORD_LEN-1:0] dma_rdata;
  logic                dma_done;

  logic                mem_en;
  logic                mem_we;
  logic [WORD_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;

  // Arbiter view: takes requests, returns results, drives the memory.
  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output pipe_stall, pipe_rdata, pipe_done,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view: requesters and the memory device.
  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  pipe_stall, pipe_rdata, pipe_done,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port fixed-latency data memory between the pipeline (PIPE)
// and a DMA port: fixed PIPE priority with a starvation limit for DMA.
module dmem_port_arbiter #(
  parameter int WORD_LEN   = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int   LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int   STV_W    = $clog2(STARVE_MAX + 1);
  localparam int   NREQ     = 2;
  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_wdata_q, mem_wdata_d;

  logic                dma_win;
  logic                grant;
  logic                capture;
  logic [NREQ-1:0]     done_w;
  logic [WORD_LEN-1:0] rdata_q [NREQ];

  // DMA only beats a concurrent PIPE request once it has been passed over
  // STARVE_MAX times in a row.
  assign dma_win = bus.dma_req && (!bus.pipe_req || (starve_cnt_q == STV_W'(STARVE_MAX)));
  assign grant   = dma_win || bus.pipe_req;
  assign capture = (state_q == ACCESS) && (lat_cnt_q == '0) && !mem_we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d     = ACCESS;
          owner_d     = dma_win ? OWN_DMA : OWN_PIPE;
          mem_en_d    = 1'b1;
          mem_we_d    = dma_win ? bus.dma_we    : bus.pipe_we;
          mem_addr_d  = dma_win ? bus.dma_addr  : bus.pipe_addr;
          mem_wdata_d = dma_win ? bus.dma_wdata : bus.pipe_wdata;
          lat_cnt_d   = LAT_W'(MEM_LAT - 1);
          if (dma_win) begin
            starve_cnt_d = '0;
          end else if (bus.dma_req && (starve_cnt_q != STV_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          state_d  = DONE;
          mem_we_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Index 0 is PIPE, index 1 is DMA, matching the owner encoding.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign done_w[gi] = (state_q == DONE) && (owner_q == 1'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q[gi] <= '0;
      end else if (capture && (owner_q == 1'(gi))) begin
        rdata_q[gi] <= bus.mem_rdata;
      end
    end
  end

  assign bus.pipe_stall = bus.pipe_req && !done_w[0];
  assign bus.pipe_done  = done_w[0];
  assign bus.dma_done   = done_w[1];
  assign bus.pipe_rdata = rdata_q[0];
  assign bus.dma_rdata  = rdata_q[1];
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
